gp_register_file: RTL and testbench
===================================

Name: gp_register_file

Overview:
- General-purpose register file; the responder side of the decode stage's register-read interface.
- Serves two combinational read ports (top/bot) to instruction decode.
- Accepts up to two byte writes per cycle from writeback; the two write ports are driven by the pipeline's reg_file_wen.
- Provides same-cycle write-to-read bypass, a debug read port, and write-collision detection.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 4, register address width.
- NUM_REGS, 16, number of registers; must equal 2**ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- reg_file_ren  in  2  read enables; bit0 = top port, bit1 = bot port.
- rd_addr_top  in  ADDR_W  top read address.
- rd_addr_bot  in  ADDR_W  bot read address.
- reg_file_data_top  out  DATA_W  top read data, to decode.
- reg_file_data_bot  out  DATA_W  bot read data, to decode.
- reg_file_wen  in  2  write enables from writeback; bit0 = top write port, bit1 = bot write port.
- wr_addr_top  in  ADDR_W  top write address.
- wr_addr_bot  in  ADDR_W  bot write address.
- wr_data_top  in  DATA_W  top write data.
- wr_data_bot  in  DATA_W  bot write data.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  registered debug read data.
- write_collision  out  1  one-cycle pulse: both write ports targeted the same address.
- written_mask  out  NUM_REGS  bit i set once register i has been written since reset.

Behaviour:
- Reset (nreset low, async): all registers = 0x00; dbg_data = 0x00; write_collision = 0; written_mask = 0. Held for the whole time nreset is low; a write coincident with reset assertion is dropped.
- Storage: NUM_REGS x DATA_W flops. Writes occur on the rising clock edge.
- Write port top: if reg_file_wen[0], reg[wr_addr_top] <= wr_data_top.
- Write port bot: if reg_file_wen[1], reg[wr_addr_bot] <= wr_data_bot.
- Same-address dual write (wen == 2'b11 and wr_addr_top == wr_addr_bot): top port wins; bot data discarded; write_collision = 1 in the following cycle only, otherwise 0.
- Reads are combinational, zero latency, so decode uses data in the same cycle.
- Read enable: reg_file_ren[n] == 0 -> that data output = 0x00 regardless of address.
- Bypass (write-first): an enabled read whose address matches an active same-cycle write returns the write data, not the stored value.
  - Priority when both write ports hit the read address: top write data, consistent with the collision rule.
  - The stored value becomes identical after the edge.
- Both read ports may read the same address; both return the same value.
- Debug port: dbg_data <= bypassed value of reg[dbg_addr] each cycle, using the same bypass rules; 1-cycle latency; no enable.
- written_mask: bit i set at the edge on which any write port writes register i; cleared only by reset; never cleared by a later write.
- No address range checking is needed; all ADDR_W codes are valid since NUM_REGS = 2**ADDR_W.
- No stall or back-pressure: every write is accepted the cycle it is presented.
- X-safety: with wen = 0, write address and data inputs have no effect on state or outputs.

Test Plan:
- Reset: nreset low mid-run after writing reg3=0x5A -> reg3 reads 0x00 with ren=2'b01; written_mask = 0; write_collision = 0; dbg_data = 0x00.
- Basic write/read:
  - Cycle 1: wen=2'b01, wr_addr_top=4, wr_data_top=0xC3.
  - Cycle 2: ren=2'b11, rd_addr_top=4, rd_addr_bot=0.
  - Expected: data_top=0xC3, data_bot=0x00; written_mask=0x0010.
- Bypass: same cycle wen=2'b10, wr_addr_bot=7, wr_data_bot=0x99, ren=2'b01, rd_addr_top=7 -> data_top=0x99 combinationally, before the edge; next cycle still 0x99.
- Collision:
  - Stimulus: wen=2'b11, both addresses 9, top=0x11, bot=0x22.
  - Expected: reg9 = 0x11; write_collision = 1 for exactly one cycle; a same-cycle bypass read of 9 returns 0x11.
- Read disable: reg2=0xFF, ren=2'b00, rd_addr_top=rd_addr_bot=2 -> both data outputs = 0x00.
- Debug/dual write:
  - Stimulus: wen=2'b11, top addr 15 = 0xAB, bot addr 0 = 0xCD.
  - Expected: next cycle dbg_addr=15 -> dbg_data=0xAB one cycle later; reg0 = 0xCD; written_mask bits 15 and 0 set.

Source files
------------

// File: rtl/gp_register_file.sv
// gp_register_file
//   General-purpose register file answering the decode stage's register-read
//   requests. Two combinational read ports (top/bot), two byte write ports
//   from writeback, write-first bypass on every read path, a registered
//   debug read port, a write-collision pulse and a sticky written mask.
//
// Ports
//   clock              system clock, rising edge
//   nreset             asynchronous active-low reset
//   reg_file_ren[1:0]  read enables (bit0 top, bit1 bot)
//   rd_addr_top/bot    read addresses
//   reg_file_data_top  top read data (combinational, 0 when disabled)
//   reg_file_data_bot  bot read data (combinational, 0 when disabled)
//   reg_file_wen[1:0]  write enables (bit0 top, bit1 bot)
//   wr_addr_top/bot    write addresses
//   wr_data_top/bot    write data
//   dbg_addr           debug read address
//   dbg_data           registered, bypassed value of reg[dbg_addr]
//   write_collision    one-cycle pulse after a same-address dual write
//   written_mask       bit i sticky-set once register i has been written
module gp_register_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic [1:0]          reg_file_ren,
  input  logic [ADDR_W-1:0]   rd_addr_top,
  input  logic [ADDR_W-1:0]   rd_addr_bot,
  output logic [DATA_W-1:0]   reg_file_data_top,
  output logic [DATA_W-1:0]   reg_file_data_bot,
  input  logic [1:0]          reg_file_wen,
  input  logic [ADDR_W-1:0]   wr_addr_top,
  input  logic [ADDR_W-1:0]   wr_addr_bot,
  input  logic [DATA_W-1:0]   wr_data_top,
  input  logic [DATA_W-1:0]   wr_data_bot,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data,
  output logic                write_collision,
  output logic [NUM_REGS-1:0] written_mask
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_dbg_data;
  logic                r_write_collision;
  logic [NUM_REGS-1:0] r_written_mask;

  logic                w_wen_top;
  logic                w_wen_bot;
  logic                w_collision;
  logic [NUM_REGS-1:0] w_wr_onehot;

  logic [DATA_W-1:0]   w_byp_top;
  logic [DATA_W-1:0]   w_byp_bot;
  logic [DATA_W-1:0]   w_byp_dbg;

  assign w_wen_top   = reg_file_wen[0];
  assign w_wen_bot   = reg_file_wen[1];
  assign w_collision = w_wen_top && w_wen_bot && (wr_addr_top == wr_addr_bot);

  // Registers touched this cycle; feeds the sticky written mask.
  always_comb begin
    w_wr_onehot = '0;
    if (w_wen_top) w_wr_onehot[wr_addr_top] = 1'b1;
    if (w_wen_bot) w_wr_onehot[wr_addr_bot] = 1'b1;
  end

  // Write-first bypass. Top is checked first so a read that hits both write
  // ports sees the same value the collision rule leaves in storage.
  always_comb begin
    w_byp_top = r_regs[rd_addr_top];
    if (w_wen_top && (wr_addr_top == rd_addr_top))
      w_byp_top = wr_data_top;
    else if (w_wen_bot && (wr_addr_bot == rd_addr_top))
      w_byp_top = wr_data_bot;
  end

  always_comb begin
    w_byp_bot = r_regs[rd_addr_bot];
    if (w_wen_top && (wr_addr_top == rd_addr_bot))
      w_byp_bot = wr_data_top;
    else if (w_wen_bot && (wr_addr_bot == rd_addr_bot))
      w_byp_bot = wr_data_bot;
  end

  always_comb begin
    w_byp_dbg = r_regs[dbg_addr];
    if (w_wen_top && (wr_addr_top == dbg_addr))
      w_byp_dbg = wr_data_top;
    else if (w_wen_bot && (wr_addr_bot == dbg_addr))
      w_byp_dbg = wr_data_bot;
  end

  assign reg_file_data_top = reg_file_ren[0] ? w_byp_top : '0;
  assign reg_file_data_bot = reg_file_ren[1] ? w_byp_bot : '0;

  // Bot is written before top so that on a same-address dual write the
  // later (top) assignment is the one that lands.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_wen_bot) r_regs[wr_addr_bot] <= wr_data_bot;
      if (w_wen_top) r_regs[wr_addr_top] <= wr_data_top;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_dbg_data        <= '0;
      r_write_collision <= 1'b0;
      r_written_mask    <= '0;
    end else begin
      r_dbg_data        <= w_byp_dbg;
      r_write_collision <= w_collision;
      r_written_mask    <= r_written_mask | w_wr_onehot;
    end
  end

  assign dbg_data        = r_dbg_data;
  assign write_collision = r_write_collision;
  assign written_mask    = r_written_mask;

endmodule

// File: tb/tb_gp_register_file.sv
module tb_gp_register_file;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  logic                clock;
  logic                nreset;
  logic [1:0]          reg_file_ren;
  logic [ADDR_W-1:0]   rd_addr_top;
  logic [ADDR_W-1:0]   rd_addr_bot;
  logic [DATA_W-1:0]   reg_file_data_top;
  logic [DATA_W-1:0]   reg_file_data_bot;
  logic [1:0]          reg_file_wen;
  logic [ADDR_W-1:0]   wr_addr_top;
  logic [ADDR_W-1:0]   wr_addr_bot;
  logic [DATA_W-1:0]   wr_data_top;
  logic [DATA_W-1:0]   wr_data_bot;
  logic [ADDR_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;
  logic                write_collision;
  logic [NUM_REGS-1:0] written_mask;

  gp_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clock             (clock),
    .nreset            (nreset),
    .reg_file_ren      (reg_file_ren),
    .rd_addr_top       (rd_addr_top),
    .rd_addr_bot       (rd_addr_bot),
    .reg_file_data_top (reg_file_data_top),
    .reg_file_data_bot (reg_file_data_bot),
    .reg_file_wen      (reg_file_wen),
    .wr_addr_top       (wr_addr_top),
    .wr_addr_bot       (wr_addr_bot),
    .wr_data_top       (wr_data_top),
    .wr_data_bot       (wr_data_bot),
    .dbg_addr          (dbg_addr),
    .dbg_data          (dbg_data),
    .write_collision   (write_collision),
    .written_mask      (written_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: expectations are queued when stimulus is applied and
  // popped when the corresponding output is sampled.
  logic [15:0] q_exp[$];
  logic [15:0] exp_v;
  logic [15:0] model_mask;

  task automatic idle();
    reg_file_wen = 2'b00;
    reg_file_ren = 2'b00;
    rd_addr_top  = '0;
    rd_addr_bot  = '0;
    wr_addr_top  = '0;
    wr_addr_bot  = '0;
    wr_data_top  = '0;
    wr_data_bot  = '0;
    dbg_addr     = '0;
  endtask

  task automatic test_reset();
    idle();
    nreset = 1'b0;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    model_mask = 16'h0000;
    reg_file_ren = 2'b11;
    q_exp.push_back(16'h0000);
    q_exp.push_back(16'h0000);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL rst_init_top: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (written_mask !== exp_v) begin
      n_err++; $display("FAIL rst_init_mask: got %h want %h", written_mask, exp_v);
    end
    // write reg3 = 0x5A, confirm, then reset mid-cycle while a write is pending
    @(negedge clock);
    reg_file_ren = 2'b00;
    reg_file_wen = 2'b01; wr_addr_top = 4'd3; wr_data_top = 8'h5A;
    @(negedge clock);
    reg_file_wen = 2'b00;
    reg_file_ren = 2'b01; rd_addr_top = 4'd3;
    q_exp.push_back(16'h005A);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL rst_pre_rd3: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    reg_file_wen = 2'b01; wr_addr_top = 4'd3; wr_data_top = 8'h77; dbg_addr = 4'd3;
    nreset = 1'b0;
    @(negedge clock);
    reg_file_wen = 2'b00;
    q_exp.push_back(16'h0000); // reg3
    q_exp.push_back(16'h0000); // mask
    q_exp.push_back(16'h0000); // collision
    q_exp.push_back(16'h0000); // dbg
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL rst_rd3: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (written_mask !== exp_v) begin
      n_err++; $display("FAIL rst_mask: got %h want %h", written_mask, exp_v);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({15'h0, write_collision} !== exp_v) begin
      n_err++; $display("FAIL rst_coll: got %b want %b", write_collision, exp_v[0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, dbg_data} !== exp_v) begin
      n_err++; $display("FAIL rst_dbg: got %h want %h", dbg_data, exp_v[7:0]);
    end
    nreset = 1'b1;
    idle();
  endtask

  task automatic test_basic();
    @(negedge clock);
    reg_file_wen = 2'b01; wr_addr_top = 4'd4; wr_data_top = 8'hC3;
    model_mask |= 16'h0010;
    @(negedge clock);
    reg_file_wen = 2'b00;
    reg_file_ren = 2'b11; rd_addr_top = 4'd4; rd_addr_bot = 4'd0;
    q_exp.push_back(16'h00C3);
    q_exp.push_back(16'h0000);
    q_exp.push_back(model_mask);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL basic_top: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_bot} !== exp_v) begin
      n_err++; $display("FAIL basic_bot: got %h want %h", reg_file_data_bot, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (written_mask !== exp_v) begin
      n_err++; $display("FAIL basic_mask: got %h want %h", written_mask, exp_v);
    end
    idle();
  endtask

  task automatic test_bypass();
    @(negedge clock);
    reg_file_wen = 2'b10; wr_addr_bot = 4'd7; wr_data_bot = 8'h99;
    reg_file_ren = 2'b01; rd_addr_top = 4'd7;
    model_mask |= 16'h0080;
    q_exp.push_back(16'h0099);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL bypass_same: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    @(negedge clock);
    reg_file_wen = 2'b00;
    q_exp.push_back(16'h0099);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL bypass_next: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    idle();
  endtask

  task automatic test_collision();
    @(negedge clock);
    reg_file_wen = 2'b11; wr_addr_top = 4'd9; wr_addr_bot = 4'd9;
    wr_data_top = 8'h11; wr_data_bot = 8'h22;
    reg_file_ren = 2'b11; rd_addr_top = 4'd9; rd_addr_bot = 4'd9;
    model_mask |= 16'h0200;
    q_exp.push_back(16'h0011);
    q_exp.push_back(16'h0011);
    q_exp.push_back(16'h0000);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL coll_byp_top: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_bot} !== exp_v) begin
      n_err++; $display("FAIL coll_byp_bot: got %h want %h", reg_file_data_bot, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({15'h0, write_collision} !== exp_v) begin
      n_err++; $display("FAIL coll_early: got %b want %b", write_collision, exp_v[0]);
    end
    @(negedge clock);
    reg_file_wen = 2'b00;
    reg_file_ren = 2'b01;
    q_exp.push_back(16'h0011);
    q_exp.push_back(16'h0001);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL coll_reg9: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({15'h0, write_collision} !== exp_v) begin
      n_err++; $display("FAIL coll_pulse: got %b want %b", write_collision, exp_v[0]);
    end
    @(negedge clock);
    q_exp.push_back(16'h0000);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({15'h0, write_collision} !== exp_v) begin
      n_err++; $display("FAIL coll_clear: got %b want %b", write_collision, exp_v[0]);
    end
    idle();
  endtask

  task automatic test_read_disable();
    @(negedge clock);
    reg_file_wen = 2'b01; wr_addr_top = 4'd2; wr_data_top = 8'hFF;
    model_mask |= 16'h0004;
    @(negedge clock);
    reg_file_wen = 2'b00;
    reg_file_ren = 2'b00; rd_addr_top = 4'd2; rd_addr_bot = 4'd2;
    q_exp.push_back(16'h0000);
    q_exp.push_back(16'h0000);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL rdis_top: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_bot} !== exp_v) begin
      n_err++; $display("FAIL rdis_bot: got %h want %h", reg_file_data_bot, exp_v[7:0]);
    end
    reg_file_ren = 2'b11;
    q_exp.push_back(16'h00FF);
    q_exp.push_back(16'h00FF);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL rsame_top: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_bot} !== exp_v) begin
      n_err++; $display("FAIL rsame_bot: got %h want %h", reg_file_data_bot, exp_v[7:0]);
    end
    idle();
  endtask

  task automatic test_debug();
    @(negedge clock);
    reg_file_wen = 2'b11; wr_addr_top = 4'd15; wr_data_top = 8'hAB;
    wr_addr_bot = 4'd0; wr_data_bot = 8'hCD;
    model_mask |= 16'h8001;
    @(negedge clock);
    reg_file_wen = 2'b00; dbg_addr = 4'd15;
    reg_file_ren = 2'b01; rd_addr_top = 4'd0;
    q_exp.push_back(16'h0000);   // no collision for distinct addresses
    q_exp.push_back(16'h00CD);
    q_exp.push_back(model_mask);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({15'h0, write_collision} !== exp_v) begin
      n_err++; $display("FAIL dual_nocoll: got %b want %b", write_collision, exp_v[0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL dual_reg0: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (written_mask !== exp_v) begin
      n_err++; $display("FAIL dual_mask: got %h want %h", written_mask, exp_v);
    end
    @(negedge clock);
    q_exp.push_back(16'h00AB);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, dbg_data} !== exp_v) begin
      n_err++; $display("FAIL dbg_r15: got %h want %h", dbg_data, exp_v[7:0]);
    end
    // debug sees bypassed bot data when only the bot port writes its address
    reg_file_wen = 2'b10; wr_addr_bot = 4'd5; wr_data_bot = 8'h3C; dbg_addr = 4'd5;
    model_mask |= 16'h0020;
    @(negedge clock);
    reg_file_wen = 2'b00;
    q_exp.push_back(16'h003C);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, dbg_data} !== exp_v) begin
      n_err++; $display("FAIL dbg_bypass: got %h want %h", dbg_data, exp_v[7:0]);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    // rewrite reg4 twice in consecutive cycles; mask bits stay set
    @(negedge clock);
    reg_file_wen = 2'b01; wr_addr_top = 4'd4; wr_data_top = 8'h01;
    @(negedge clock);
    wr_data_top = 8'h02;
    @(negedge clock);
    reg_file_wen = 2'b00;
    reg_file_ren = 2'b10; rd_addr_bot = 4'd4;
    q_exp.push_back(16'h0002);
    q_exp.push_back(model_mask);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_bot} !== exp_v) begin
      n_err++; $display("FAIL b2b_reg4: got %h want %h", reg_file_data_bot, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (written_mask !== exp_v) begin
      n_err++; $display("FAIL b2b_mask: got %h want %h", written_mask, exp_v);
    end
    // wen=0 with X addresses/data must leave state untouched
    reg_file_wen = 2'b00;
    wr_addr_top = 'x; wr_addr_bot = 'x; wr_data_top = 'x; wr_data_bot = 'x;
    @(negedge clock);
    @(negedge clock);
    reg_file_ren = 2'b11; rd_addr_top = 4'd9; rd_addr_bot = 4'd4;
    q_exp.push_back(16'h0011);
    q_exp.push_back(16'h0002);
    q_exp.push_back(model_mask);
    #1;
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_top} !== exp_v) begin
      n_err++; $display("FAIL xsafe_top: got %h want %h", reg_file_data_top, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if ({8'h00, reg_file_data_bot} !== exp_v) begin
      n_err++; $display("FAIL xsafe_bot: got %h want %h", reg_file_data_bot, exp_v[7:0]);
    end
    exp_v = q_exp.pop_front(); n_cmp++;
    if (written_mask !== exp_v) begin
      n_err++; $display("FAIL xsafe_mask: got %h want %h", written_mask, exp_v);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_mask = 16'h0000;
    idle();
    nreset = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_collision();
    test_read_disable();
    test_debug();
    test_back_to_back();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
